// File: rtl/fetch_ref_window.sv
// Rotating N-bank reference-pixel window buffer: one bank is loaded from external
// memory while the FIME and FME read ports each read a different, previously loaded bank.
module fetch_ref_window #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ROW_PELS    = 96,
    parameter int OUT_PELS    = 64,
    parameter int DEPTH       = 80,
    parameter int N_BANK      = 3,
    parameter int ADDR_W      = 7,
    parameter int X_W         = 8,
    parameter int Y_W         = 9,
    parameter int PAD         = 16,
    parameter int FIME_Y_OFF  = 4,
    parameter int FIME_WIN    = 28,
    parameter int FME_WIN     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sysif_start_i,
    input  logic [Y_W-1:0]                  sysif_total_y_i,
    input  logic                            ext_load_valid_i,
    input  logic [ADDR_W-1:0]               ext_load_addr_i,
    input  logic [ROW_PELS*PIXEL_WIDTH-1:0] ext_load_data_i,
    input  logic                            ext_load_done_i,
    input  logic [Y_W-1:0]                  fime_cur_y_i,
    input  logic [X_W-1:0]                  fime_ref_x_i,
    input  logic [ADDR_W:0]                 fime_ref_y_i,
    input  logic                            fime_ref_rden_i,
    output logic [OUT_PELS*PIXEL_WIDTH-1:0] fime_ref_pel_o,
    output logic                            fime_ref_vld_o,
    output logic                            fime_bank_rdy_o,
    input  logic [Y_W-1:0]                  fme_cur_y_i,
    input  logic [X_W-1:0]                  fme_ref_x_i,
    input  logic [ADDR_W:0]                 fme_ref_y_i,
    input  logic                            fme_ref_rden_i,
    output logic [OUT_PELS*PIXEL_WIDTH-1:0] fme_ref_pel_o,
    output logic                            fme_ref_vld_o,
    output logic                            fme_bank_rdy_o,
    output logic                            err_overrun_o
);

    localparam int WORD_W   = ROW_PELS * PIXEL_WIDTH;
    localparam int OUT_W    = OUT_PELS * PIXEL_WIDTH;
    localparam int BANK_W   = (N_BANK > 1) ? $clog2(N_BANK) : 1;
    localparam int MEM_ROWS = N_BANK * DEPTH;
    localparam int MEM_AW   = $clog2(MEM_ROWS);
    localparam int E_W      = ADDR_W + 2;

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANK - 1);
    localparam logic [BANK_W-1:0] BANK_M2   = BANK_W'(N_BANK - 2);

    // All banks share one flat array; bank b occupies rows [b*DEPTH, (b+1)*DEPTH).
    logic [WORD_W-1:0] mem [MEM_ROWS];

    logic [BANK_W-1:0] ptr_reg;
    logic [BANK_W-1:0] ptr_next;
    logic [N_BANK-1:0] bank_done_reg;
    logic [N_BANK-1:0] bank_done_next;
    logic              err_overrun_reg;
    logic              err_overrun_next;

    logic [BANK_W-1:0] rd_bank  [2];
    logic [Y_W-1:0]    rd_cur_y [2];
    logic [X_W-1:0]    rd_x     [2];
    logic [ADDR_W:0]   rd_y     [2];
    logic              rd_en    [2];
    logic [OUT_W-1:0]  rd_pel   [2];
    logic              rd_vld   [2];

    logic              wr_en;
    logic [MEM_AW-1:0] wr_idx;

    function automatic logic [MEM_AW-1:0] bank_base(input logic [BANK_W-1:0] b);
        return MEM_AW'(b) * MEM_AW'(DEPTH);
    endfunction

    // Read banks trail the write bank by one and two positions.
    assign rd_bank[0] = (ptr_reg == '0) ? LAST_BANK : ptr_reg - 1'b1;
    assign rd_bank[1] = (ptr_reg >= BANK_W'(2)) ? ptr_reg - BANK_W'(2) : ptr_reg + BANK_M2;

    assign rd_cur_y[0] = fime_cur_y_i;
    assign rd_cur_y[1] = fme_cur_y_i;
    assign rd_x[0]     = fime_ref_x_i;
    assign rd_x[1]     = fme_ref_x_i;
    assign rd_y[0]     = fime_ref_y_i;
    assign rd_y[1]     = fme_ref_y_i;
    assign rd_en[0]    = fime_ref_rden_i;
    assign rd_en[1]    = fme_ref_rden_i;

    assign fime_ref_pel_o  = rd_pel[0];
    assign fime_ref_vld_o  = rd_vld[0];
    assign fme_ref_pel_o   = rd_pel[1];
    assign fme_ref_vld_o   = rd_vld[1];
    assign fime_bank_rdy_o = bank_done_reg[rd_bank[0]];
    assign fme_bank_rdy_o  = bank_done_reg[rd_bank[1]];
    assign err_overrun_o   = err_overrun_reg;

    always_comb begin
        ptr_next         = ptr_reg;
        bank_done_next   = bank_done_reg;
        err_overrun_next = 1'b0;
        // Done lands on the bank being left, before the rotation clears the new one.
        if (ext_load_done_i) begin
            bank_done_next[ptr_reg] = 1'b1;
        end
        if (sysif_start_i) begin
            err_overrun_next         = !bank_done_reg[ptr_reg] && !ext_load_done_i;
            ptr_next                 = (ptr_reg == LAST_BANK) ? '0 : ptr_reg + 1'b1;
            bank_done_next[ptr_next] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg         <= '0;
            bank_done_reg   <= '0;
            err_overrun_reg <= 1'b0;
        end else begin
            ptr_reg         <= ptr_next;
            bank_done_reg   <= bank_done_next;
            err_overrun_reg <= err_overrun_next;
        end
    end

    assign wr_en  = ext_load_valid_i && !rst
                    && ({1'b0, ext_load_addr_i} < (ADDR_W + 1)'(DEPTH));
    assign wr_idx = bank_base(ptr_reg) + MEM_AW'(ext_load_addr_i);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= ext_load_data_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            localparam int OFF = (gi == 0) ? FIME_Y_OFF : 0;
            localparam int WIN = (gi == 0) ? FIME_WIN : FME_WIN;

            logic [E_W-1:0]    e_row;
            logic [E_W-1:0]    row;
            logic              row_ok;
            logic [MEM_AW-1:0] rd_idx;
            logic [WORD_W-1:0] rd_data_reg;
            logic              oob_reg;
            logic [X_W-1:0]    x_reg;
            logic              vld_reg;
            logic [WORD_W-1:0] word;
            logic [WORD_W-1:0] sh_word;
            logic [31:0]       sh_amt;

            always_comb begin
                e_row = E_W'(rd_y[gi]) + E_W'(OFF);
                if (rd_cur_y[gi] == '0) begin
                    row = (e_row < E_W'(PAD)) ? '0 : e_row - E_W'(PAD);
                end else if (rd_cur_y[gi] == sysif_total_y_i) begin
                    row = (e_row >= E_W'(DEPTH)) ? E_W'(DEPTH - 1) : e_row;
                end else begin
                    row = e_row;
                end
                // Unclamped rows past the bank must not alias into a neighbouring bank.
                row_ok = (row < E_W'(DEPTH));
                rd_idx = bank_base(rd_bank[gi]) + (row_ok ? MEM_AW'(row) : '0);
            end

            // Bank choice is folded into rd_idx, so a rotation right after rden is harmless.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_reg <= '0;
                    oob_reg     <= 1'b0;
                    x_reg       <= '0;
                    vld_reg     <= 1'b0;
                end else begin
                    vld_reg <= rd_en[gi];
                    if (rd_en[gi]) begin
                        rd_data_reg <= mem[rd_idx];
                        oob_reg     <= !row_ok;
                        x_reg       <= rd_x[gi];
                    end
                end
            end

            always_comb begin
                word    = oob_reg ? '0 : rd_data_reg;
                sh_amt  = 32'(x_reg) * 32'(PIXEL_WIDTH);
                sh_word = word << sh_amt;
            end

            assign rd_pel[gi] = OUT_W'(sh_word >> (WIN * PIXEL_WIDTH));
            assign rd_vld[gi] = vld_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_ref_window.sv
// Bench for fetch_ref_window: a 3-bank and a 4-bank instance share stimulus and are
// checked against a per-instance bank/row/pel model.
module tb_fetch_ref_window;

    localparam int WW = 768;
    localparam int OW = 512;
    localparam int DEPTH = 80;

    logic clk;
    logic rst;
    logic start;
    logic [8:0] total_y;
    logic ld_valid;
    logic [6:0] ld_addr;
    logic [WW-1:0] ld_data;
    logic ld_done;
    logic [8:0] cur_y [2];
    logic [7:0] ref_x [2];
    logic [7:0] ref_y [2];
    logic rden [2];

    logic [1:0][1:0][OW-1:0] pel_obs;
    logic [1:0][1:0] vld_obs;
    logic [1:0][1:0] rdy_obs;
    logic [1:0] err_obs;

    logic [WW-1:0] mmem [2][4][DEPTH];
    int mptr [2];
    bit mdone [2][4];
    logic [OW-1:0] exp_pel [2][2];
    logic exp_vld [2][2];
    logic exp_err [2];

    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_ref_window dut3 (
        .clk(clk), .rst(rst), .sysif_start_i(start), .sysif_total_y_i(total_y),
        .ext_load_valid_i(ld_valid), .ext_load_addr_i(ld_addr),
        .ext_load_data_i(ld_data), .ext_load_done_i(ld_done),
        .fime_cur_y_i(cur_y[0]), .fime_ref_x_i(ref_x[0]), .fime_ref_y_i(ref_y[0]),
        .fime_ref_rden_i(rden[0]), .fime_ref_pel_o(pel_obs[0][0]),
        .fime_ref_vld_o(vld_obs[0][0]), .fime_bank_rdy_o(rdy_obs[0][0]),
        .fme_cur_y_i(cur_y[1]), .fme_ref_x_i(ref_x[1]), .fme_ref_y_i(ref_y[1]),
        .fme_ref_rden_i(rden[1]), .fme_ref_pel_o(pel_obs[0][1]),
        .fme_ref_vld_o(vld_obs[0][1]), .fme_bank_rdy_o(rdy_obs[0][1]),
        .err_overrun_o(err_obs[0])
    );

    fetch_ref_window #(.N_BANK(4)) dut4 (
        .clk(clk), .rst(rst), .sysif_start_i(start), .sysif_total_y_i(total_y),
        .ext_load_valid_i(ld_valid), .ext_load_addr_i(ld_addr),
        .ext_load_data_i(ld_data), .ext_load_done_i(ld_done),
        .fime_cur_y_i(cur_y[0]), .fime_ref_x_i(ref_x[0]), .fime_ref_y_i(ref_y[0]),
        .fime_ref_rden_i(rden[0]), .fime_ref_pel_o(pel_obs[1][0]),
        .fime_ref_vld_o(vld_obs[1][0]), .fime_bank_rdy_o(rdy_obs[1][0]),
        .fme_cur_y_i(cur_y[1]), .fme_ref_x_i(ref_x[1]), .fme_ref_y_i(ref_y[1]),
        .fme_ref_rden_i(rden[1]), .fme_ref_pel_o(pel_obs[1][1]),
        .fme_ref_vld_o(vld_obs[1][1]), .fme_bank_rdy_o(rdy_obs[1][1]),
        .err_overrun_o(err_obs[1])
    );

    // ---------------- reference model ----------------
    function automatic int nb(input int i);
        return (i == 0) ? 3 : 4;
    endfunction

    function automatic int bank_of(input int i, input int p);
        return (mptr[i] - 1 - p + nb(i)) % nb(i);
    endfunction

    function automatic int row_of(input int p, input int cy, input int ty, input int y);
        int e;
        e = y + ((p == 0) ? 4 : 0);
        if (cy == 0) return (e < 16) ? 0 : e - 16;
        if (cy == ty) return (e >= DEPTH) ? DEPTH - 1 : e;
        return e;
    endfunction

    // Output pel k is stored pel (win + k - x), or zero when that falls outside the row.
    function automatic logic [OW-1:0] mdl_pel(input logic [WW-1:0] row, input int win, input int x);
        logic [OW-1:0] r;
        int src;
        r = '0;
        for (int k = 0; k < 64; k++) begin
            src = win + k - x;
            if (src >= 0 && src < 96) r[k*8 +: 8] = row[src*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] model_read(input int i, input int p);
        int r;
        r = row_of(p, int'(cur_y[p]), int'(total_y), int'(ref_y[p]));
        return mdl_pel(mmem[i][bank_of(i, p)][r], (p == 0) ? 28 : 32, int'(ref_x[p]));
    endfunction

    function automatic logic [WW-1:0] rand_row();
        logic [WW-1:0] r;
        for (int k = 0; k < WW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Advance model by one clock edge using the current inputs, then step the DUTs.
    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mptr[i] = 0;
                for (int b = 0; b < 4; b++) mdone[i][b] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    exp_pel[i][p] = '0;
                    exp_vld[i][p] = 1'b0;
                end
                exp_err[i] = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    exp_vld[i][p] = rden[p];
                    if (rden[p]) exp_pel[i][p] = model_read(i, p);
                end
                if (ld_valid && ld_addr < DEPTH) mmem[i][mptr[i]][ld_addr] = ld_data;
                exp_err[i] = start && !mdone[i][mptr[i]] && !ld_done;
                if (ld_done) mdone[i][mptr[i]] = 1'b1;
                if (start) begin
                    mptr[i] = (mptr[i] + 1) % nb(i);
                    mdone[i][mptr[i]] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // done_mode: 0 = start without done, 1 = done then start, 2 = done with start
    task automatic load_phase(input int pattern, input int done_mode);
        logic [7:0] v;
        for (int r = 0; r < DEPTH; r++) begin
            v = 8'(r);
            ld_valid = 1'b1;
            ld_addr = 7'(r);
            ld_data = (pattern == 0) ? {96{v}} : rand_row();
            tick();
        end
        ld_valid = 1'b0;
        if (done_mode == 1) begin
            ld_done = 1'b1;
            tick();
            ld_done = 1'b0;
        end
        ld_done = (done_mode == 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_done = 1'b0;
    endtask

    task automatic rand_reads();
        int c;
        for (int p = 0; p < 2; p++) begin
            c = $urandom_range(0, 2);
            rden[p] = 1'b1;
            ref_x[p] = ($urandom_range(0, 7) == 0) ? 8'd200 : 8'($urandom_range(0, 100));
            if (c == 0) begin
                cur_y[p] = 9'd0;
                ref_y[p] = 8'($urandom_range(0, (p == 0) ? 91 : 95));
            end else if (c == 1) begin
                cur_y[p] = total_y;
                ref_y[p] = 8'($urandom_range(0, 255));
            end else begin
                cur_y[p] = 9'd5;
                ref_y[p] = 8'($urandom_range(0, (p == 0) ? 75 : 79));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (pel_obs[i][p] !== '0 || vld_obs[i][p] !== 1'b0 || rdy_obs[i][p] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset inst%0d port%0d pel_nonzero=%0b vld=%b rdy=%b expected all 0",
                             i, p, pel_obs[i][p] != '0, vld_obs[i][p], rdy_obs[i][p]);
                end
            end
            checks++;
            if (err_obs[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_err inst%0d got=%b exp=0", i, err_obs[i]);
            end
        end
    endtask

    task automatic test_load_basic();
        logic [7:0] v;
        logic [OW-1:0] e14;
        v = 8'd14;
        e14 = {64{v}};
        load_phase(0, 1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rdy_obs[i][0] !== 1'b1 || rdy_obs[i][1] !== 1'b0) begin
                failures++;
                $display("FAIL basic_rdy inst%0d got fime=%b fme=%b exp fime=1 fme=0",
                         i, rdy_obs[i][0], rdy_obs[i][1]);
            end
        end
        total_y = 9'd9;
        cur_y[0] = 9'd5; ref_y[0] = 8'd10; ref_x[0] = 8'd0; rden[0] = 1'b1;
        tick();
        rden[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (vld_obs[i][0] !== 1'b1 || pel_obs[i][0] !== e14) begin
                failures++;
                $display("FAIL basic_read inst%0d vld=%b got=%h exp=%h", i, vld_obs[i][0], pel_obs[i][0], e14);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (vld_obs[i][0] !== 1'b0 || pel_obs[i][0] !== e14) begin
                failures++;
                $display("FAIL basic_hold inst%0d vld=%b got=%h exp=%h", i, vld_obs[i][0], pel_obs[i][0], e14);
            end
        end
    endtask

    task automatic test_rotation();
        for (int ph = 0; ph < 2; ph++) begin
            load_phase(1, 2);
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (rdy_obs[i][p] !== mdone[i][bank_of(i, p)]) begin
                        failures++;
                        $display("FAIL rot_rdy ph%0d inst%0d port%0d got=%b exp=%b",
                                 ph, i, p, rdy_obs[i][p], mdone[i][bank_of(i, p)]);
                    end
                end
            end
            for (int n = 0; n < 4; n++) begin
                rand_reads();
                tick();
                for (int i = 0; i < 2; i++) begin
                    for (int p = 0; p < 2; p++) begin
                        checks++;
                        if (vld_obs[i][p] !== exp_vld[i][p] || pel_obs[i][p] !== exp_pel[i][p]) begin
                            failures++;
                            $display("FAIL rot_read ph%0d inst%0d port%0d bank%0d got=%h exp=%h",
                                     ph, i, p, bank_of(i, p), pel_obs[i][p], exp_pel[i][p]);
                        end
                    end
                end
            end
            rden[0] = 1'b0;
            rden[1] = 1'b0;
        end
    endtask

    task automatic test_clamp();
        // {port, cur_y, total_y, y, expected row}
        int tbl [8][5] = '{'{0, 0, 9, 8, 0}, '{0, 0, 9, 20, 8}, '{1, 0, 9, 10, 0},
                          '{1, 0, 9, 40, 24}, '{0, 9, 9, 77, 79}, '{1, 9, 9, 85, 79},
                          '{1, 9, 9, 50, 50}, '{1, 0, 0, 40, 24}};
        logic [OW-1:0] want;
        int p;
        for (int t = 0; t < 8; t++) begin
            p = tbl[t][0];
            total_y = 9'(tbl[t][2]);
            cur_y[p] = 9'(tbl[t][1]);
            ref_y[p] = 8'(tbl[t][3]);
            ref_x[p] = 8'd0;
            rden[p] = 1'b1;
            tick();
            rden[p] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                want = mdl_pel(mmem[i][bank_of(i, p)][tbl[t][4]], (p == 0) ? 28 : 32, 0);
                checks++;
                if (pel_obs[i][p] !== want) begin
                    failures++;
                    $display("FAIL clamp case%0d inst%0d port%0d row%0d got=%h exp=%h",
                             t, i, p, tbl[t][4], pel_obs[i][p], want);
                end
            end
        end
        total_y = 9'd9;
        for (int n = 0; n < 20; n++) begin
            rand_reads();
            tick();
            for (int i = 0; i < 2; i++) begin
                for (int q = 0; q < 2; q++) begin
                    checks++;
                    if (pel_obs[i][q] !== exp_pel[i][q]) begin
                        failures++;
                        $display("FAIL clamp_rand inst%0d port%0d y=%0d cur=%0d got=%h exp=%h",
                                 i, q, ref_y[q], cur_y[q], pel_obs[i][q], exp_pel[i][q]);
                    end
                end
            end
        end
        rden[0] = 1'b0;
        rden[1] = 1'b0;
    endtask

    task automatic test_shift();
        logic [7:0] xs [2];
        logic [OW-1:0] zero;
        xs[0] = 8'd5;
        xs[1] = 8'd200;
        zero = '0;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 2; p++) begin
                cur_y[p] = 9'd5; ref_y[p] = 8'd33; ref_x[p] = xs[s]; rden[p] = 1'b1;
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (pel_obs[i][p] !== exp_pel[i][p] || (s == 1 && pel_obs[i][p] !== zero)) begin
                        failures++;
                        $display("FAIL shift x=%0d inst%0d port%0d got=%h exp=%h",
                                 xs[s], i, p, pel_obs[i][p], exp_pel[i][p]);
                    end
                end
            end
        end
        rden[0] = 1'b0;
        rden[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int cyc = 0; cyc < DEPTH + 16; cyc++) begin
            rand_reads();
            ld_valid = 1'b1;
            ld_addr = (cyc < DEPTH) ? 7'(cyc) : 7'($urandom_range(DEPTH, 127));
            ld_data = rand_row();
            ld_done = (cyc == DEPTH + 10);
            start = (cyc == DEPTH + 10) || (cyc == DEPTH + 11 && 1'b0);
            tick();
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (vld_obs[i][p] !== exp_vld[i][p] || pel_obs[i][p] !== exp_pel[i][p]) begin
                        failures++;
                        $display("FAIL b2b cyc%0d inst%0d port%0d got=%h exp=%h",
                                 cyc, i, p, pel_obs[i][p], exp_pel[i][p]);
                    end
                end
            end
        end
        ld_valid = 1'b0; ld_done = 1'b0; start = 1'b0;
        rden[0] = 1'b0; rden[1] = 1'b0;
    endtask

    task automatic test_overrun();
        load_phase(1, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (err_obs[i] !== 1'b1 || exp_err[i] !== 1'b1) begin
                failures++;
                $display("FAIL overrun_pulse inst%0d got=%b exp=1", i, err_obs[i]);
            end
            checks++;
            if (rdy_obs[i][0] !== 1'b0) begin
                failures++;
                $display("FAIL overrun_rdy inst%0d got=%b exp=0", i, rdy_obs[i][0]);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (err_obs[i] !== 1'b0) begin
                failures++;
                $display("FAIL overrun_width inst%0d got=%b exp=0", i, err_obs[i]);
            end
        end
        load_phase(1, 2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (err_obs[i] !== 1'b0 || rdy_obs[i][0] !== 1'b1) begin
                failures++;
                $display("FAIL overrun_same_cycle inst%0d err=%b rdy=%b exp err=0 rdy=1",
                         i, err_obs[i], rdy_obs[i][0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int r = 0; r < 30; r++) begin
            ld_valid = 1'b1; ld_addr = 7'(r); ld_data = rand_row();
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rdy_obs[i][0] !== 1'b0 || rdy_obs[i][1] !== 1'b0) begin
                failures++;
                $display("FAIL midrst_rdy inst%0d got fime=%b fme=%b exp 0 0", i, rdy_obs[i][0], rdy_obs[i][1]);
            end
        end
        load_phase(1, 1);
        for (int n = 0; n < 6; n++) begin
            rand_reads();
            rden[1] = 1'b0;
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (pel_obs[i][0] !== exp_pel[i][0] || rdy_obs[i][0] !== 1'b1) begin
                    failures++;
                    $display("FAIL midrst_read inst%0d rdy=%b got=%h exp=%h",
                             i, rdy_obs[i][0], pel_obs[i][0], exp_pel[i][0]);
                end
            end
        end
        rden[0] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; total_y = 9'd9;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
        for (int p = 0; p < 2; p++) begin
            cur_y[p] = '0; ref_x[p] = '0; ref_y[p] = '0; rden[p] = 1'b0;
        end
        test_reset();
        test_load_basic();
        test_rotation();
        test_clamp();
        test_shift();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
